// File: rtl/imem_loader.sv
// imem_loader: boot-time loader that assembles 16-bit words from a byte stream and writes them to the IF instruction memory.
// Latency: wen fires the cycle after the low-byte transfer; pc_reset follows the last WRITE, rd_en/done one cycle later.
// Backpressure: byte_ready is high only in header/data byte states and drops for the WRITE cycle (one word per 3 cycles).
//
// Ports:
//   clk, reset (sync, active-low)  | start: begin a load (IDLE/RUN/ERR only)
//   byte_in/byte_valid/byte_ready  : stream input handshake
//   din/wen/pc_reset/rd_en         : IF-stage instruction memory controls
//   words_written/busy/done/error  : load status
module imem_loader #(
  parameter int ADDR_W    = 9,
  parameter int MAX_WORDS = 512
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [7:0]        byte_in,
  input  logic              byte_valid,
  output logic              byte_ready,
  output logic [15:0]       din,
  output logic              wen,
  output logic              pc_reset,
  output logic              rd_en,
  output logic [ADDR_W:0]   words_written,
  output logic              busy,
  output logic              done,
  output logic              error
);

  localparam logic [3:0] S_IDLE    = 4'd0;
  localparam logic [3:0] S_CNT_HI  = 4'd1;
  localparam logic [3:0] S_CNT_LO  = 4'd2;
  localparam logic [3:0] S_DATA_HI = 4'd3;
  localparam logic [3:0] S_DATA_LO = 4'd4;
  localparam logic [3:0] S_WRITE   = 4'd5;
  localparam logic [3:0] S_PCRST   = 4'd6;
  localparam logic [3:0] S_RUN     = 4'd7;
  localparam logic [3:0] S_ERR     = 4'd8;

  logic [3:0]      state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic [15:0]     din_q, din_d;
  logic [ADDR_W:0] ww_q, ww_d;

  logic            xfer;
  logic [15:0]     n_full;
  logic [ADDR_W:0] ww_inc;

  // All status outputs decode directly from state, so reset to IDLE clears them.
  assign byte_ready    = (state_q == S_CNT_HI) || (state_q == S_CNT_LO) ||
                         (state_q == S_DATA_HI) || (state_q == S_DATA_LO);
  assign busy          = byte_ready || (state_q == S_WRITE) || (state_q == S_PCRST);
  assign wen           = (state_q == S_WRITE);
  assign pc_reset      = (state_q == S_PCRST);
  assign rd_en         = (state_q == S_RUN);
  assign done          = (state_q == S_RUN);
  assign error         = (state_q == S_ERR);
  assign din           = din_q;
  assign words_written = ww_q;

  assign xfer   = byte_valid && byte_ready;
  // Completed word count as it will be once the low header byte lands.
  assign n_full = {cnt_q[15:8], byte_in};
  assign ww_inc = ww_q + 1'b1;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    din_d   = din_q;
    ww_d    = ww_q;
    case (state_q)
      S_IDLE, S_RUN, S_ERR: begin
        if (start) begin
          state_d = S_CNT_HI;
          ww_d    = '0;
        end
      end
      S_CNT_HI: begin
        if (xfer) begin
          cnt_d[15:8] = byte_in;
          state_d     = S_CNT_LO;
        end
      end
      S_CNT_LO: begin
        if (xfer) begin
          cnt_d[7:0] = byte_in;
          if ((n_full == 16'd0) || (n_full > 16'(MAX_WORDS))) state_d = S_ERR;
          else                                                state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          din_d[15:8] = byte_in;
          state_d     = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          din_d[7:0] = byte_in;
          state_d    = S_WRITE;
        end
      end
      S_WRITE: begin
        ww_d = ww_inc;
        if (16'(ww_inc) == cnt_q) state_d = S_PCRST;
        else                      state_d = S_DATA_HI;
      end
      S_PCRST: state_d = S_RUN;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 16'h0000;
      din_q   <= 16'h0000;
      ww_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      din_q   <= din_d;
      ww_q    <= ww_d;
    end
  end

endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that drives the write side of the IF stage's instruction memory. It accepts a byte stream over a valid/ready handshake and assembles 16-bit instruction words from it. Each word is written through the IF `din`/`wen` port. After the last word it pulses `pc_reset` and then holds `rd_en` high, so the processor fetches the loaded program from address 0.

## Interface
Parameters:
- ADDR_W, 9, width of the instruction address and word counter (matches the IF `next_address` width)
- MAX_WORDS, 512, largest legal program length in words

Ports:
- clk  in  1  system clock; all logic is on the rising edge
- reset  in  1  synchronous, active-low reset
- start  in  1  one-cycle request to begin a load; honoured only in IDLE, RUN or ERR
- byte_in  in  8  stream byte
- byte_valid  in  1  byte_in is valid this cycle
- byte_ready  out  1  loader can accept a byte this cycle
- din  out  16  instruction word, connected to IF `din`
- wen  out  1  instruction memory write strobe, connected to IF `wen`
- pc_reset  out  1  PC rewind pulse, connected to IF `pc_reset`
- rd_en  out  1  fetch enable, connected to IF `rd_en`
- words_written  out  ADDR_W+1  number of words written in the current load
- busy  out  1  a load is in progress
- done  out  1  load completed; the processor is running
- error  out  1  header was illegal; the load was aborted

## Operation
- Stream format: 2-byte word count N, high byte first, followed by 2N data bytes. Each word is sent high byte first.
- A byte transfers when byte_valid && byte_ready on a rising edge.
- States and transitions:
  - IDLE: start -> CNT_HI.
  - CNT_HI: a transfer loads N[15:8] -> CNT_LO.
  - CNT_LO: a transfer loads N[7:0]. If the completed N is 0 or greater than MAX_WORDS -> ERR, otherwise -> DATA_HI.
  - DATA_HI: a transfer latches din[15:8] -> DATA_LO.
  - DATA_LO: a transfer latches din[7:0] -> WRITE.
  - WRITE: wen=1 for exactly one cycle and words_written increments. If words_written (new value) == N -> PCRST, else -> DATA_HI.
  - PCRST: pc_reset=1 for exactly one cycle -> RUN.
  - RUN: rd_en=1 and done=1. start -> CNT_HI, with rd_en and done cleared in that same transition.
  - ERR: error=1. start -> CNT_HI.
- byte_ready is 1 only in CNT_HI, CNT_LO, DATA_HI and DATA_LO. It is 0 in IDLE, WRITE, PCRST, RUN and ERR.
- busy is 1 in the states CNT_HI through PCRST.
- start is ignored while busy.
- A start that takes effect clears words_written and error.
- din holds its last assembled value, and changes only on the DATA_HI and DATA_LO transfers.
- wen is never asserted outside WRITE. pc_reset is never asserted outside PCRST.
- Words are written in stream order. The IF memory's internal write pointer supplies the addresses, so the loader issues exactly N wen pulses per load.

## Timing
- Reset (reset==0 at a rising edge) forces:
  - state = IDLE
  - din = 16'h0000
  - words_written = 0
  - byte_ready, wen, pc_reset, rd_en, busy, done and error all 0
- Reset takes priority over every other input. A reset mid-load abandons the load with no further wen or pc_reset pulse.
- Word latency: wen is high in the cycle immediately after the low-byte transfer, with din already stable in that cycle.
- Sustained throughput: one word per 3 cycles (two byte transfers plus WRITE), with byte_ready dropping for the WRITE cycle.
- byte_valid gaps stall the FSM in its current state with no side effects. byte_in is ignored when no transfer occurs.
- After the final word:
  - pc_reset is high in the cycle after the final WRITE.
  - rd_en and done go high in the following cycle and stay high until the next start or reset.
- Minimum total load time for N words, with no gaps: 2 + 3N + 1 cycles from the first header transfer to rd_en rising.

## Test plan
- Nominal load: reset low for 2 cycles, start, then stream 00 05 00 01 00 02 00 03 00 04 00 05. Required response:
  - 5 wen pulses, with din = 0001, 0002, 0003, 0004, 0005.
  - 1 pc_reset pulse.
  - rd_en=1, done=1, words_written=5.
  - IF fetch then returns 0001..0005 on successive rising edges.
- Back-pressure and gaps: same stream with byte_valid dropped for 1–3 random cycles between bytes. Required response: identical wen/din sequence, and no extra wen pulses.
- Illegal headers:
  - Header 00 00 -> error=1, byte_ready=0, no wen and no pc_reset.
  - Header 02 01 (N=513) -> same response.
  - A following start with a legal stream then loads normally, and error clears.
- Reset mid-load: assert reset after the 3rd data word (words_written=3). Required response: all outputs return to their reset values next cycle, and there are no further wen or pc_reset pulses.
- Reload from RUN: after a done load, pulse start and stream 00 01 AB CD. Required response:
  - rd_en drops in the cycle after start.
  - One wen pulse with din=ABCD, then pc_reset, then rd_en=1, with words_written=1.
- Start while busy: pulse start during DATA_LO. Required response: no effect, and the load completes normally.
